// File: rtl/pwm_capture.sv
// PWM input capture: period and high time between rising edges of signal_i.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to add a FILTER_LEN-sample glitch filter.
module pwm_capture #(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_en_i,
    input  logic                 cfg_clr_i,
    input  logic                 signal_i,
    output logic [CNT_WIDTH-1:0] period_o,
    output logic [CNT_WIDTH-1:0] high_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 ovr_o,
    output logic                 to_o,
    output logic                 busy_o
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    if (CNT_WIDTH < 4 || SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_cfg
        $error("pwm_capture: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_sync;
    logic                   s_lvl;
    logic                   s_prev;
    logic                   rise;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   hcnt_q, hcnt_d;
    logic                   new_res;
    logic                   to_set;
    logic                   ovr_set;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], signal_i};
        end
    end

    assign s_sync = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [FW-1:0] flt_cnt_q;
    logic          flt_q;

    // Counts consecutive samples that disagree with the filtered level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flt_q     <= 1'b0;
            flt_cnt_q <= '0;
        end else if (s_sync == flt_q) begin
            flt_cnt_q <= '0;
        end else if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
            flt_q     <= s_sync;
            flt_cnt_q <= '0;
        end else begin
            flt_cnt_q <= flt_cnt_q + 1'b1;
        end
    end

    assign s_lvl = flt_q;
`else
    assign s_lvl = s_sync;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_prev <= 1'b0;
        end else begin
            s_prev <= s_lvl;
        end
    end

    assign rise = s_lvl & ~s_prev;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hcnt_d  = hcnt_q;
        new_res = 1'b0;
        to_set  = 1'b0;
        if (!cfg_en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            hcnt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ARM;
                    cnt_d   = '0;
                    hcnt_d  = '0;
                end
                ARM: begin
                    if (rise) begin
                        state_d = MEASURE;
                        cnt_d   = ONE;
                        hcnt_d  = ONE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        new_res = 1'b1;
                        cnt_d   = ONE;
                        hcnt_d  = ONE;
                    end else if (&cnt_q) begin
                        // Period too long to represent: abandon and re-arm.
                        to_set  = 1'b1;
                        state_d = ARM;
                        cnt_d   = '0;
                        hcnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                        if (s_lvl && !(&hcnt_q)) begin
                            hcnt_d = hcnt_q + ONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign ovr_set = new_res & valid_o & ~ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            period_o <= '0;
            high_o   <= '0;
            valid_o  <= 1'b0;
        end else if (!cfg_en_i) begin
            valid_o <= 1'b0;
        end else if (new_res) begin
            if (!valid_o || ready_i) begin
                period_o <= cnt_q;
                high_o   <= hcnt_q;
                valid_o  <= 1'b1;
            end
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

    // A clear in the same cycle as a new event leaves the flag set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovr_o <= 1'b0;
            to_o  <= 1'b0;
        end else begin
            ovr_o <= (ovr_o & ~cfg_clr_i) | ovr_set;
            to_o  <= (to_o & ~cfg_clr_i) | to_set;
        end
    end

    assign busy_o = (state_q == MEASURE);

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Input-capture unit that measures the PWM waveforms produced by timer_module channels.
- Samples one asynchronous input and measures period and high time in clk_i cycles between consecutive rising edges.
- Presents each measurement on a valid/ready output, with sticky overrun and timeout flags.
- Sits beside the advanced timer in the peripheral subsystem; can loop back pwm_o for self-test.

Parameters:
CNT_WIDTH, 16, width of period/high counters and result ports (>=4)
SYNC_STAGES, 2, input synchronizer depth (>=2)
FILTER_LEN, 4, stable-sample count for optional glitch filter (>=1)

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous active-high reset
cfg_en_i  input  1  capture enable; low forces IDLE
cfg_clr_i  input  1  single-cycle pulse, clears ovr_o and to_o
signal_i  input  1  asynchronous waveform under measurement
period_o  output  CNT_WIDTH  cycles between last two rising edges
high_o  output  CNT_WIDTH  cycles signal was high within that period
valid_o  output  1  result valid
ready_i  input  1  consumer accepts result
ovr_o  output  1  sticky: result dropped because the previous result was unconsumed
to_o  output  1  sticky: counter saturated before the next rising edge
busy_o  output  1  state is MEASURE

Behaviour:
- Reset: all outputs 0, state IDLE, synchronizer and edge registers 0, counters 0.
- Sync: signal_i passes through SYNC_STAGES flops to s_sync. s_prev is s_sync delayed 1 cycle. rise = s_sync & ~s_prev; fall = ~s_sync & s_prev.
- States:
  - IDLE: counters held at 0. Goes to ARM when cfg_en_i=1.
  - ARM: waits for rise. On rise: cnt<=1; hcnt<=1; go to MEASURE. No result is produced on this first edge.
  - MEASURE: cnt increments each cycle. hcnt increments while s_sync=1 and stops once fall is seen.
- On rise in MEASURE:
  - period result <= cnt; high result <= hcnt.
  - cnt<=1; hcnt<=1; stay in MEASURE.
  - Example: rises N cycles apart give period N. A high phase of H sampled cycles gives high H.
- Result register and handshake:
  - If valid_o=0, or (valid_o & ready_i) in the same cycle: period_o/high_o load and valid_o<=1 on the next edge.
  - If valid_o=1 & ready_i=0: the new result is discarded, period_o/high_o are unchanged, and ovr_o<=1.
  - When valid_o & ready_i with no new result, valid_o<=0.
  - period_o/high_o are stable whenever valid_o=1.
- Latency: signal_i rising edge to valid_o is SYNC_STAGES+1 cycles, +/-1 cycle of sampling uncertainty.
- Saturation: if cnt reaches all-ones in MEASURE, set to_o<=1, go to ARM, no result. A constant-level input therefore yields only to_o.
- cfg_en_i falling: next cycle state=IDLE, valid_o<=0, counters cleared. Sticky flags are kept.
- cfg_clr_i in the same cycle as a new overrun/timeout: the set wins (flag=1).
- Asynchronous reset mid-measurement: immediate return to reset values. After reset deassertion, the first rise only arms.
- All counter arithmetic is unsigned, CNT_WIDTH bits, and saturating. high_o<=period_o always holds.

Optional Feature:
Macro PWM_CAPTURE_GLITCH_FILTER_EN.
- Defined: a filter stage sits between the synchronizer and edge detection. The filtered level changes only after the synchronized input holds the new value for FILTER_LEN consecutive cycles. Pulses shorter than FILTER_LEN are ignored. Latency grows by FILTER_LEN cycles. period/high values are unchanged for clean inputs.
- Undefined: no filter; the FILTER_LEN parameter is ignored.

Test Plan:
1. cfg_en_i=1, ready_i=1, signal_i period 10 with 3 high cycles, 4 periods -> 3 results, each period_o=10, high_o=3; first edge produces none; ovr_o=to_o=0.
2. ready_i=0, two full periods of 8 -> valid_o=1 holding the first result (period 8), second result dropped, ovr_o=1. Pulse cfg_clr_i -> ovr_o=0.
3. CNT_WIDTH=4, one rise then signal_i held low 20 cycles -> to_o=1 after cnt reaches 15, state ARM, valid_o never asserted.
4. rst_i asserted mid-MEASURE (cnt=5) -> all outputs 0 immediately. After release, first rise produces no result; next rise 6 cycles later gives period_o=6.
5. cfg_en_i dropped while valid_o=1 -> valid_o=0 next cycle, busy_o=0; re-enable -> ARM.
6. With PWM_CAPTURE_GLITCH_FILTER_EN, FILTER_LEN=4: 2-cycle high glitch inside a period-12 waveform -> period_o=12, glitch not counted. Without the macro -> glitch produces extra short results.
